// File: rtl/p_deser_pkg.sv
// -----------------------------------------------------------------------------
// p_deser_pkg
// Shared definitions for the p_deser deserializer slice.
//   - p_deser_state_e : FSM state encoding (FILL = 1'b0, FULL = 1'b1)
//   - p_deser_cw()    : ceil(log2(n)) clamped to a minimum of 1, used to size
//                       counters and indices in parametrized blocks.
// -----------------------------------------------------------------------------
package p_deser_pkg;

    typedef enum logic {
        P_DESER_FILL = 1'b0,
        P_DESER_FULL = 1'b1
    } p_deser_state_e;

    // A counter of n values never gets narrower than one bit.
    function automatic int p_deser_cw(input int n);
        int w;
        w = $clog2(n);
        if (w < 32'sd1) begin
            return 32'sd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/p_deser_if.sv
// -----------------------------------------------------------------------------
// p_deser_if
// Handshake bundle between a narrow word producer, the deserializer and a
// wide set consumer.
//   in_bus/in_valid/in_ready        : one word per accepted handshake
//   out_buses/out_valid/out_ready   : one assembled set of NB_OUTS words
//   fill_count                      : words held in the incomplete set
// Modports:
//   slave  - the deserializer's view
//   master - the surrounding environment's view
// -----------------------------------------------------------------------------
interface p_deser_if
    import p_deser_pkg::*;
#(
    parameter int BUS_WIDTH = 1,
    parameter int NB_OUTS   = 2
);
    localparam int CW = p_deser_cw(NB_OUTS + 1);

    logic [BUS_WIDTH-1:0] in_bus;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] out_buses [NB_OUTS-1:0];
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        fill_count;

    modport slave (
        input  in_bus, in_valid, out_ready,
        output in_ready, out_buses, out_valid, fill_count
    );

    modport master (
        output in_bus, in_valid, out_ready,
        input  in_ready, out_buses, out_valid, fill_count
    );

endinterface

// File: rtl/p_reg_en.sv
// -----------------------------------------------------------------------------
// p_reg_en
// BUS_WIDTH-wide register with write enable and asynchronous active-high
// reset to zero. One instance holds one output slot of p_deser.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   i_en  - write enable
//   i_d   - data in
//   o_q   - registered data out
// -----------------------------------------------------------------------------
module p_reg_en #(
    parameter int BUS_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic [BUS_WIDTH-1:0] i_d,
    output logic [BUS_WIDTH-1:0] o_q
);

    logic [BUS_WIDTH-1:0] r_q;

    // Slot storage: load on enable, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/p_deser.sv
// -----------------------------------------------------------------------------
// p_deser
// Deserializer: gathers NB_OUTS consecutive words from a single input bus
// into NB_OUTS parallel slots (slot 0 first) and presents the complete set
// with a valid/ready handshake.
// Parameters:
//   BUS_WIDTH - width of each word / output slot
//   NB_OUTS   - words per set (>= 1)
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - p_deser_if.slave (input word stream, output set, fill_count)
// Configuration:
//   P_DESER_BYPASS_EN - when defined, a word may be accepted in the same
//   cycle the full set drains, removing the bubble between sets.
// -----------------------------------------------------------------------------
module p_deser
    import p_deser_pkg::*;
#(
    parameter int BUS_WIDTH = 1,
    parameter int NB_OUTS   = 2
) (
    input  logic        clk,
    input  logic        reset,
    p_deser_if.slave    bus
);

    localparam int             CW       = p_deser_cw(NB_OUTS + 1);
    localparam int             IW       = p_deser_cw(NB_OUTS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NB_OUTS - 1);

    p_deser_state_e       r_state;
    p_deser_state_e       w_state_nxt;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nxt;
    logic [CW-1:0]        r_fill;
    logic [CW-1:0]        w_fill_nxt;
    // Low during reset and until the first edge after it, gating in_ready.
    logic                 r_live;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [NB_OUTS-1:0]   w_slot_en;
    logic [BUS_WIDTH-1:0] w_slot_q [NB_OUTS-1:0];

    // FSM state, slot index, fill counter and post-reset enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= P_DESER_FILL;
            r_idx   <= '0;
            r_fill  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_fill  <= w_fill_nxt;
            r_live  <= 1'b1;
        end
    end

    // Next-state, index/count update and input-ready decode.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fill_nxt  = r_fill;
        w_in_ready  = 1'b0;
        case (r_state)
            P_DESER_FILL: begin
                w_in_ready = r_live;
                if (bus.in_valid && w_in_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = P_DESER_FULL;
                        w_idx_nxt   = '0;
                        w_fill_nxt  = '0;
                    end else begin
                        w_idx_nxt  = r_idx + IW'(1);
                        w_fill_nxt = r_fill + CW'(1);
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            P_DESER_FULL: begin
`ifdef P_DESER_BYPASS_EN
                w_in_ready = r_live & bus.out_ready;
`else
                w_in_ready = 1'b0;
`endif
                if (bus.out_ready) begin
                    w_state_nxt = P_DESER_FILL;
`ifdef P_DESER_BYPASS_EN
                    // Word accepted while draining lands in slot 0 (idx is 0 here).
                    if (bus.in_valid && w_in_ready) begin
                        if (NB_OUTS == 1) begin
                            w_state_nxt = P_DESER_FULL;
                            w_idx_nxt   = '0;
                            w_fill_nxt  = '0;
                        end else begin
                            w_idx_nxt  = IW'(1);
                            w_fill_nxt = CW'(1);
                        end
                    end else begin
                        w_idx_nxt = r_idx;
                    end
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = P_DESER_FILL;
                w_idx_nxt   = '0;
                w_fill_nxt  = '0;
            end
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    genvar k;
    generate
        for (k = 0; k < NB_OUTS; k++) begin : g_slot
            assign w_slot_en[k] = w_accept & (r_idx == IW'(k));

            p_reg_en #(
                .BUS_WIDTH (BUS_WIDTH)
            ) u_slot (
                .clk   (clk),
                .reset (reset),
                .i_en  (w_slot_en[k]),
                .i_d   (bus.in_bus),
                .o_q   (w_slot_q[k])
            );

            assign bus.out_buses[k] = w_slot_q[k];
        end
    endgenerate

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == P_DESER_FULL);
    assign bus.fill_count = r_fill;

endmodule

// File: tb/tb_p_deser.sv
// -----------------------------------------------------------------------------
// tb_p_deser
// Directed self-checking bench for p_deser. Two instances share clk/reset:
//   u_dut4 : BUS_WIDTH=8, NB_OUTS=4
//   u_dut1 : BUS_WIDTH=1, NB_OUTS=1
// Expected values are hand-computed constants. P_DESER_BYPASS_EN selects the
// bypass-build expectations where behaviour differs.
// -----------------------------------------------------------------------------
module tb_p_deser;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    p_deser_if #(.BUS_WIDTH(8), .NB_OUTS(4)) if4 ();
    p_deser_if #(.BUS_WIDTH(1), .NB_OUTS(1)) if1 ();

    p_deser #(.BUS_WIDTH(8), .NB_OUTS(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    p_deser #(.BUS_WIDTH(1), .NB_OUTS(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Concatenated view of the 4-slot output, slot 3 in the top byte.
    function automatic logic [31:0] bus4();
        return {if4.out_buses[3], if4.out_buses[2], if4.out_buses[1], if4.out_buses[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] words_a [4];

    // Directed sequence.
    initial begin
        words_a[0] = 8'hA1; words_a[1] = 8'hB2; words_a[2] = 8'hC3; words_a[3] = 8'hD4;
        reset         = 1'b0;
        if4.in_bus    = 8'h00;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b0;
        if1.in_bus    = 1'b0;
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b0;

        // Reset asserted between edges: outputs clear with no clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, if4.out_valid}, 32'h0);
        chk("rst_buses",     bus4(),                 32'h0);
        chk("rst_fill",      {29'd0, if4.fill_count}, 32'h0);
        chk("rst_in_ready",  {31'd0, if4.in_ready},  32'h0);
        chk("rst_valid_n1",  {31'd0, if1.out_valid}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_before_edge", {31'd0, if4.in_ready}, 32'h0);
        tick();
        chk("rdy_after_edge",  {31'd0, if4.in_ready}, 32'h1);

        // Basic back-to-back fill.
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1;
            if4.in_bus   = words_a[i];
            tick();
            if (i < 3) begin
                chk("fill_step", {29'd0, if4.fill_count}, 32'(i + 1));
                chk("fill_nvalid", {31'd0, if4.out_valid}, 32'h0);
            end
        end
        if4.in_bus = 8'hEE;
        chk("full_valid", {31'd0, if4.out_valid},  32'h1);
        chk("full_rdy",   {31'd0, if4.in_ready},   32'h0);
        chk("full_buses", bus4(),                  32'hD4C3B2A1);
        chk("full_fill",  {29'd0, if4.fill_count}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {31'd0, if4.out_valid}, 32'h1);
            chk("hold_buses", bus4(),                 32'hD4C3B2A1);
        end
        if4.in_valid = 1'b0;

        // Drain.
        if4.out_ready = 1'b1;
        @(negedge clk);
`ifdef P_DESER_BYPASS_EN
        chk("drain_rdy", {31'd0, if4.in_ready}, 32'h1);
`else
        chk("drain_rdy", {31'd0, if4.in_ready}, 32'h0);
`endif
        tick();
        if4.out_ready = 1'b0;
        chk("drained_valid", {31'd0, if4.out_valid},  32'h0);
        chk("drained_fill",  {29'd0, if4.fill_count}, 32'h0);
        chk("drained_hold",  bus4(),                  32'hD4C3B2A1);
        chk("drained_rdy",   {31'd0, if4.in_ready},   32'h1);

        // out_ready in FILL with nothing pending changes nothing.
        if4.out_ready = 1'b1;
        tick();
        tick();
        if4.out_ready = 1'b0;
        chk("idle_ordy_valid", {31'd0, if4.out_valid},  32'h0);
        chk("idle_ordy_fill",  {29'd0, if4.fill_count}, 32'h0);

        // Gapped fill, 8'hFF driven in the gaps.
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1;
            if4.in_bus   = 8'(i + 1);
            tick();
            chk("gap_fill", {29'd0, if4.fill_count}, (i == 3) ? 32'h0 : 32'(i + 1));
            if (i == 0) begin
                chk("stale_slot1", {24'd0, if4.out_buses[1]}, 32'hB2);
            end
            if4.in_valid = 1'b0;
            if4.in_bus   = 8'hFF;
            tick();
            chk("gap_hold", {29'd0, if4.fill_count}, (i == 3) ? 32'h0 : 32'(i + 1));
        end
        chk("gap_valid", {31'd0, if4.out_valid}, 32'h1);
        chk("gap_buses", bus4(),                 32'h04030201);
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("gap_drained", {31'd0, if4.out_valid}, 32'h0);

`ifdef P_DESER_BYPASS_EN
        // Continuous stream with a always-ready consumer: one set per 4 cycles.
        if4.in_valid  = 1'b1;
        if4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if4.in_bus = 8'(8'h10 + i);
            tick();
            if (i == 3) begin
                chk("byp_set1_valid", {31'd0, if4.out_valid}, 32'h1);
                chk("byp_set1_buses", bus4(),                 32'h13121110);
            end
            if (i == 4) begin
                chk("byp_mid_valid", {31'd0, if4.out_valid},  32'h0);
                chk("byp_mid_fill",  {29'd0, if4.fill_count}, 32'h1);
                chk("byp_mid_slot0", {24'd0, if4.out_buses[0]}, 32'h14);
            end
            if (i == 7) begin
                chk("byp_set2_valid", {31'd0, if4.out_valid}, 32'h1);
                chk("byp_set2_buses", bus4(),                 32'h17161514);
            end
        end
        if4.in_valid = 1'b0;
        tick();
        if4.out_ready = 1'b0;
        chk("byp_end_valid", {31'd0, if4.out_valid},  32'h0);
        chk("byp_end_fill",  {29'd0, if4.fill_count}, 32'h0);
`endif

        // Reset in the middle of a set.
        if4.in_valid = 1'b1;
        if4.in_bus   = 8'h11;
        tick();
        if4.in_bus   = 8'h22;
        tick();
        if4.in_valid = 1'b0;
        chk("mid_fill", {29'd0, if4.fill_count}, 32'h2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_fill",  {29'd0, if4.fill_count}, 32'h0);
        chk("midrst_valid", {31'd0, if4.out_valid},  32'h0);
        chk("midrst_buses", bus4(),                  32'h0);
        chk("midrst_rdy",   {31'd0, if4.in_ready},   32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_rdy_back", {31'd0, if4.in_ready}, 32'h1);
        if4.in_valid = 1'b1;
        if4.in_bus   = 8'h33;
        tick();
        if4.in_valid = 1'b0;
        chk("midrst_next_fill", {29'd0, if4.fill_count}, 32'h1);
        chk("midrst_next_slot", bus4(),                  32'h00000033);

        // NB_OUTS=1, BUS_WIDTH=1.
        if1.in_valid = 1'b1;
        if1.in_bus   = 1'b1;
        tick();
        chk("n1_valid",  {31'd0, if1.out_valid},     32'h1);
        chk("n1_bus",    {31'd0, if1.out_buses[0]},  32'h1);
        chk("n1_fill",   {31'd0, if1.fill_count},    32'h0);
        if1.in_bus    = 1'b0;
        if1.out_ready = 1'b1;
        tick();
`ifdef P_DESER_BYPASS_EN
        chk("n1_byp_valid", {31'd0, if1.out_valid},    32'h1);
        chk("n1_byp_bus",   {31'd0, if1.out_buses[0]}, 32'h0);
        if1.in_valid = 1'b0;
        tick();
        if1.out_ready = 1'b0;
        chk("n1_byp_drain", {31'd0, if1.out_valid},    32'h0);
`else
        chk("n1_drain_valid", {31'd0, if1.out_valid},    32'h0);
        chk("n1_drain_hold",  {31'd0, if1.out_buses[0]}, 32'h1);
        if1.out_ready = 1'b0;
        tick();
        if1.in_valid = 1'b0;
        chk("n1_second_valid", {31'd0, if1.out_valid},    32'h1);
        chk("n1_second_bus",   {31'd0, if1.out_buses[0]}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p_deser.md
Name: p_deser

Overview:
- Parametrized deserializer: the fan-out counterpart of the boolean library's many-bus-to-one reduction.
- Accepts one BUS_WIDTH word per handshake on a single input bus and distributes consecutive words into NB_OUTS parallel output buses, slot 0 first.
- Presents the assembled set with a valid/ready handshake.
- Sits between narrow producers (e.g. serial operand fetch) and wide parallel consumers (e.g. the multi-input boolean/ALU stages).

Parameters:
- BUS_WIDTH, 1, width of each word and of each output bus.
- NB_OUTS, 2, number of output buses (words per assembled set); legal range ≥1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_bus  input  BUS_WIDTH  incoming word.
- in_valid  input  1  in_bus holds a valid word.
- in_ready  output  1  block can accept a word this cycle.
- out_buses  output  BUS_WIDTH x NB_OUTS (unpacked array [NB_OUTS-1:0])  assembled words; out_buses[k] = k-th accepted word of the set.
- out_valid  output  1  full set present on out_buses.
- out_ready  input  1  consumer takes the set this cycle.
- fill_count  output  CW = max(1, clog2(NB_OUTS+1))  words held in the current, not yet complete set.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=FILL, slot index idx=0, fill_count=0, out_valid=0.
  - All out_buses slots = 0.
  - in_ready=0 while reset is high; in_ready=1 from the first clock edge after deassertion.
- States: FILL, FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - Accept on in_valid & in_ready: slot[idx] <= in_bus, idx <= idx+1, fill_count <= fill_count+1.
  - If the accepted word lands in idx==NB_OUTS-1: next state FULL, idx <= 0, fill_count <= 0.
- FULL:
  - out_valid=1, in_ready=0 (base build).
  - out_buses stable while out_valid=1 and out_ready=0.
  - On out_ready=1: next state FILL; slot contents are held, not cleared.
- Latency:
  - The last word accepted at edge N gives out_valid=1 in the cycle after edge N.
  - Base throughput: NB_OUTS+1 cycles per set (one bubble cycle in FULL).
- Slots not yet overwritten in FILL keep their previous-set values; they are visible on out_buses but qualified invalid by out_valid=0.
- NB_OUTS=1: every accepted word moves straight to FULL; idx is held at 0 at all times.
- idx never exceeds NB_OUTS-1; no wrap beyond the last slot.
- in_valid=0 in FILL: nothing changes. out_ready while out_valid=0: ignored.
- Reset asserted mid-set or in FULL: partial set discarded, all state returns to reset values immediately.
- in_bus is sampled only on accept; values held without in_ready are never captured.

Optional Feature:
- Macro: P_DESER_BYPASS_EN.
- Defined:
  - In FULL, in_ready = out_ready.
  - A word accepted in the same cycle the set drains is written to slot 0; next state FILL with idx=1, fill_count=1.
  - For NB_OUTS=1: next state stays FULL with the new word.
  - Sustained throughput becomes one set per NB_OUTS cycles.
- Not defined:
  - in_ready=0 in FULL regardless of out_ready; behaviour exactly as in Behaviour above.

Decomposition:
- Shared package contents:
  - state encoding constants P_DESER_FILL=1'b0, P_DESER_FULL=1'b1;
  - the counter-width helper function (clog2 with minimum 1), reused by other parametrized blocks.
- One sub-module: p_reg_en, a BUS_WIDTH register with async active-high reset to 0 and a write enable.
  - Instantiated NB_OUTS times via generate.
  - Slot k enable = accept & (idx==k).

Test Plan:
- Reset/idle: BUS_WIDTH=8, NB_OUTS=4; assert reset mid-cycle → out_valid=0, all out_buses=8'h00, fill_count=0 without a clock edge; one edge after deassert, in_ready=1.
- Basic fill: send 8'hA1, 8'hB2, 8'hC3, 8'hD4 back-to-back with out_ready=0 → out_valid=1 the cycle after the 4th accept; out_buses[0..3]=A1,B2,C3,D4; in_ready=0; outputs stable for 5 held cycles.
- Gapped input: same words with in_valid low on alternate cycles, values 8'hFF driven during the gaps → fill_count steps 1,2,3 then 0; gap values never captured.
- Drain and bubble (base build): out_ready=1 in FULL → FILL next cycle, in_ready=0 during the drain cycle; next set 8'h01..8'h04 assembled correctly.
- Bypass (P_DESER_BYPASS_EN): continuous in_valid, out_ready=1 → a set completes every 4 cycles, first word of the next set lands in slot 0, fill_count=1 after the drain cycle.
- Edge cases:
  - NB_OUTS=1, BUS_WIDTH=1: each accepted bit yields out_valid the next cycle.
  - Reset asserted after 2 of 4 words: fill_count=0; next accepted word lands in slot 0.
